// File: rtl/mem_arbiter_if.sv
// Unified memory request interface between the cache wrappers, the arbiter and uni2axi.
// Requester side drives the request payload; memory side answers with ready/rdata.
interface uni_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
);
  logic              valid;
  logic              ready;
  logic              reqtyp;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        size;
  logic              cachable;
  logic [DATA_W-1:0] rdata;

  modport Master (
    output valid, reqtyp, addr, wdata, size, cachable,
    input  ready, rdata
  );

  modport Slave (
    input  valid, reqtyp, addr, wdata, size, cachable,
    output ready, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter sharing one memory path between the instruction and data caches.
// A grant is held until the memory returns its single-cycle ready pulse.
//
//   state | meaning
//   IDLE  | no grant; arbitration happens here, outputs quiet
//   GNT_I | instruction port owns memIf_M until ready
//   GNT_D | data port owns memIf_M until ready
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 128,
  parameter int FIX_PRIO = 0
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  uni_if.Slave  iMemIf_S,
  uni_if.Slave  dMemIf_S,
  uni_if.Master memIf_M
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  logic [1:0] state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic [3:0] starv_q, starv_d;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    starv_d    = starv_q;
    case (state_q)
      IDLE: begin
        if (iMemIf_S.valid && dMemIf_S.valid) begin
          if (FIX_PRIO != 0) begin
            // the instruction port is the only one that can lose a tie here
            if (starv_q == 4'd15) begin
              state_d = GNT_I;
              starv_d = 4'd0;
            end else begin
              state_d = GNT_D;
              starv_d = starv_q + 4'd1;
            end
          end else begin
            state_d = (last_gnt_q == LAST_I) ? GNT_D : GNT_I;
          end
        end else if (iMemIf_S.valid) begin
          state_d = GNT_I;
          if (FIX_PRIO != 0) starv_d = 4'd0;
        end else if (dMemIf_S.valid) begin
          state_d = GNT_D;
        end
      end
      GNT_I: begin
        if (memIf_M.ready) begin
          state_d    = IDLE;
          last_gnt_d = LAST_I;
        end
      end
      GNT_D: begin
        if (memIf_M.ready) begin
          state_d    = IDLE;
          last_gnt_d = LAST_D;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= LAST_I;
      starv_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      starv_q    <= starv_d;
    end
  end

  // Payload follows the owner combinationally; an owner dropping valid is forwarded as-is.
  always_comb begin
    memIf_M.valid    = 1'b0;
    memIf_M.reqtyp   = 1'b0;
    memIf_M.addr     = {ADDR_W{1'b0}};
    memIf_M.wdata    = {DATA_W{1'b0}};
    memIf_M.size     = 3'd0;
    memIf_M.cachable = 1'b0;
    iMemIf_S.ready   = 1'b0;
    dMemIf_S.ready   = 1'b0;
    case (state_q)
      GNT_I: begin
        memIf_M.valid    = iMemIf_S.valid;
        memIf_M.reqtyp   = iMemIf_S.reqtyp;
        memIf_M.addr     = iMemIf_S.addr;
        memIf_M.wdata    = iMemIf_S.wdata;
        memIf_M.size     = iMemIf_S.size;
        memIf_M.cachable = iMemIf_S.cachable;
        iMemIf_S.ready   = memIf_M.ready;
      end
      GNT_D: begin
        memIf_M.valid    = dMemIf_S.valid;
        memIf_M.reqtyp   = dMemIf_S.reqtyp;
        memIf_M.addr     = dMemIf_S.addr;
        memIf_M.wdata    = dMemIf_S.wdata;
        memIf_M.size     = dMemIf_S.size;
        memIf_M.cachable = dMemIf_S.cachable;
        dMemIf_S.ready   = memIf_M.ready;
      end
      default: ;
    endcase
  end

  // rdata is shared; each requester qualifies it with its own ready
  assign iMemIf_S.rdata = memIf_M.rdata;
  assign dMemIf_S.rdata = memIf_M.rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed corner cases plus randomized traffic scored against
// a queue-based model of the arbitration rules, on a round-robin and a fixed-priority instance.
module tb_mem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 128;
  localparam int NRAND = 40;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  uni_if #(.ADDR_W(AW), .DATA_W(DW)) i_if ();
  uni_if #(.ADDR_W(AW), .DATA_W(DW)) d_if ();
  uni_if #(.ADDR_W(AW), .DATA_W(DW)) m_if ();
  uni_if #(.ADDR_W(AW), .DATA_W(DW)) fi_if ();
  uni_if #(.ADDR_W(AW), .DATA_W(DW)) fd_if ();
  uni_if #(.ADDR_W(AW), .DATA_W(DW)) fm_if ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIX_PRIO(0)) u_rr (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .iMemIf_S(i_if), .dMemIf_S(d_if), .memIf_M(m_if)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIX_PRIO(1)) u_fix (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .iMemIf_S(fi_if), .dMemIf_S(fd_if), .memIf_M(fm_if)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          reqtyp;
    logic [2:0]    size;
    logic          cachable;
  } req_t;

  req_t iq[$];
  req_t dq[$];
  logic fq[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout/empty, want response", nm);
  endtask

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return {a ^ 32'h5A5A_5A5A, ~a, a + 32'd7, a};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_i(input logic v, input logic [AW-1:0] a);
    i_if.valid = v; i_if.addr = a; i_if.wdata = {4{a}};
    i_if.reqtyp = 1'b0; i_if.size = 3'd4; i_if.cachable = 1'b1;
  endtask

  task automatic set_d(input logic v, input logic [AW-1:0] a);
    d_if.valid = v; d_if.addr = a; d_if.wdata = {4{~a}};
    d_if.reqtyp = 1'b1; d_if.size = 3'd2; d_if.cachable = 1'b0;
  endtask

  task automatic wait_done(output logic who, output logic [AW-1:0] a, output bit ok);
    ok = 1'b0; who = 1'b0; a = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge i_clk);
      if (m_if.valid && m_if.ready) begin
        who = d_if.ready; a = m_if.addr; ok = 1'b1;
        return;
      end
    end
  endtask

  // memory model for the round-robin instance
  logic mem_stall = 1'b0;
  logic mem_rand  = 1'b0;
  logic mem_spur  = 1'b0;
  int   mem_lat   = 0;

  initial begin
    int cnt;
    cnt = -1;
    m_if.ready = 1'b0;
    m_if.rdata = '0;
    forever begin
      @(posedge i_clk);
      #1;
      m_if.ready = 1'b0;
      if (!i_rst_n) cnt = -1;
      if (m_if.valid && !mem_stall) begin
        if (cnt < 0) cnt = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
        if (cnt == 0) begin
          m_if.ready = 1'b1;
          m_if.rdata = rd_fn(m_if.addr);
          cnt = -1;
        end else begin
          cnt--;
        end
      end else if (mem_spur && !m_if.valid) begin
        m_if.ready = 1'b1;
      end
    end
  end

  // memory model for the fixed-priority instance: answers in the first grant cycle
  initial begin
    fm_if.ready = 1'b0;
    fm_if.rdata = '0;
    forever begin
      @(posedge i_clk);
      #1;
      fm_if.ready = fm_if.valid & i_rst_n;
    end
  end

  always @(negedge i_clk) begin
    if (fm_if.valid && fm_if.ready && fq.size() > 0) begin
      logic e;
      e = fq.pop_front();
      chk("fix_grant_order", DW'({fd_if.ready, fi_if.ready}), DW'(e ? 2'b10 : 2'b01));
    end
  end

  // scoreboard monitor for randomized traffic on the round-robin instance
  logic mon_en  = 1'b0;
  logic busy    = 1'b0;
  logic owner   = 1'b0;
  logic last    = 1'b0;
  logic gap_chk = 1'b0;
  logic i_prev  = 1'b0;
  logic d_prev  = 1'b0;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      busy = 1'b0; gap_chk = 1'b0; last = 1'b0;
    end else if (mon_en) begin
      if (gap_chk) begin
        chk("idle_gap", DW'(m_if.valid), DW'(1'b0));
        gap_chk = 1'b0;
      end
      if (!busy && m_if.valid) begin
        owner = (i_prev && d_prev) ? ~last : d_prev;
        if ((owner ? dq.size() : iq.size()) == 0) fail_now("grant_without_request");
        else chk("grant_addr", DW'(m_if.addr), DW'(owner ? dq[0].addr : iq[0].addr));
        busy = 1'b1;
      end
      if (busy && m_if.ready) begin
        req_t e;
        chk("ready_route", DW'({d_if.ready, i_if.ready}), DW'(owner ? 2'b10 : 2'b01));
        if ((owner ? dq.size() : iq.size()) == 0) begin
          fail_now("completion_without_request");
        end else begin
          if (owner) e = dq.pop_front();
          else e = iq.pop_front();
          chk("done_addr", DW'(m_if.addr), DW'(e.addr));
          chk("done_wdata", m_if.wdata, e.wdata);
          chk("done_ctl", DW'({m_if.reqtyp, m_if.size, m_if.cachable}),
              DW'({e.reqtyp, e.size, e.cachable}));
          chk("done_rdata", owner ? d_if.rdata : i_if.rdata, rd_fn(e.addr));
        end
        last = owner; busy = 1'b0; gap_chk = 1'b1;
      end
    end
    i_prev = i_if.valid;
    d_prev = d_if.valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, ip, dp, bad, ngr, losses;
    int   done_cyc[$];
    logic who_q[$];
    logic vh[64];
    logic who;
    logic [AW-1:0] a;
    bit   ok;

    set_i(1'b0, '0); set_d(1'b0, '0);
    fi_if.valid = 1'b0; fi_if.addr = '0; fi_if.wdata = '0;
    fi_if.reqtyp = 1'b0; fi_if.size = '0; fi_if.cachable = 1'b0;
    fd_if.valid = 1'b0; fd_if.addr = '0; fd_if.wdata = '0;
    fd_if.reqtyp = 1'b0; fd_if.size = '0; fd_if.cachable = 1'b0;
    foreach (vh[k]) vh[k] = 1'b0;

    repeat (2) tick();
    chk("rst_m_valid", DW'(m_if.valid), DW'(1'b0));
    chk("rst_slave_ready", DW'({i_if.ready, d_if.ready}), DW'(2'b00));
    chk("rst_m_payload", DW'({m_if.addr, m_if.size, m_if.cachable, m_if.reqtyp}), DW'(0));
    chk("rst_fix_valid", DW'(fm_if.valid), DW'(1'b0));
    i_rst_n = 1'b1;
    tick();

    // continuous tie on round-robin: D first after reset, then alternate, one idle between
    mem_lat = 1;
    set_i(1'b1, 32'h0000_1000); set_d(1'b1, 32'h0000_2001);
    cyc = 0;
    while (done_cyc.size() < 4 && cyc < 64) begin
      @(negedge i_clk);
      vh[cyc] = m_if.valid;
      if (m_if.valid && m_if.ready) begin
        done_cyc.push_back(cyc);
        who_q.push_back(d_if.ready);
      end
      cyc++;
    end
    tick();
    set_i(1'b0, '0); set_d(1'b0, '0);
    if (done_cyc.size() != 4) begin
      fail_now("rr_tie_timeout");
    end else begin
      for (int k = 0; k < 4; k++) chk("rr_tie_order", DW'(who_q[k]), DW'(k % 2 == 0));
      for (int k = 0; k < 3; k++)
        chk("rr_tie_gap", DW'({vh[done_cyc[k]+1], vh[done_cyc[k]+2]}), DW'(2'b01));
    end

    // single I request, memory answers three cycles after valid
    mem_lat = 3;
    tick();
    set_i(1'b1, 32'h8000_0000);
    @(negedge i_clk);
    chk("arb_cycle_valid", DW'(m_if.valid), DW'(1'b0));
    ip = 0; dp = 0; bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      if (k == 0) chk("single_addr_c1", DW'(m_if.addr), DW'(32'h8000_0000));
      if (m_if.valid && m_if.addr != 32'h8000_0000) bad++;
      ip += int'(i_if.ready);
      dp += int'(d_if.ready);
      if (i_if.ready) begin
        chk("single_rdata", i_if.rdata, rd_fn(32'h8000_0000));
        tick();
        set_i(1'b0, '0);
      end
    end
    chk("single_i_pulses", DW'(ip), DW'(1));
    chk("single_d_pulses", DW'(dp), DW'(0));
    chk("single_addr_stable", DW'(bad), DW'(0));

    // D arrives during GNT_I: grant holds, D served after one idle cycle
    mem_lat = 0; mem_stall = 1'b1;
    tick();
    set_i(1'b1, 32'h0000_0100);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("hold_grant_i", DW'(m_if.addr), DW'(32'h0000_0100));
    tick();
    set_d(1'b1, 32'h0000_0201);
    repeat (3) begin
      @(negedge i_clk);
      chk("hold_payload_i", DW'(m_if.addr), DW'(32'h0000_0100));
      chk("hold_no_d_ready", DW'(d_if.ready), DW'(1'b0));
    end
    mem_stall = 1'b0;
    @(negedge i_clk);
    chk("hold_i_done", DW'({d_if.ready, i_if.ready}), DW'(2'b01));
    tick();
    set_i(1'b0, '0);
    @(negedge i_clk);
    chk("hold_idle", DW'(m_if.valid), DW'(1'b0));
    @(negedge i_clk);
    chk("hold_then_d", DW'({m_if.valid, m_if.addr}), DW'({1'b1, 32'h0000_0201}));
    chk("hold_d_ready", DW'(d_if.ready), DW'(1'b1));
    tick();
    set_d(1'b0, '0);

    // spurious memory ready while idle
    @(negedge i_clk);
    mem_spur = 1'b1;
    @(negedge i_clk);
    mem_spur = 1'b0;
    chk("spur_no_ready", DW'({i_if.ready, d_if.ready, m_if.valid}), DW'(3'b000));
    @(negedge i_clk);
    chk("spur_stay_idle", DW'(m_if.valid), DW'(1'b0));

    // reset in the middle of a D grant
    tick();
    mem_stall = 1'b1;
    set_d(1'b1, 32'h0000_0301);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst_mid_granted", DW'(m_if.valid), DW'(1'b1));
    i_rst_n = 1'b0;
    mem_spur = 1'b1;
    #1;
    chk("rst_mid_valid", DW'(m_if.valid), DW'(1'b0));
    chk("rst_mid_addr", DW'(m_if.addr), DW'(0));
    chk("rst_mid_dready", DW'(d_if.ready), DW'(1'b0));
    @(negedge i_clk);
    chk("rst_mid_ready_blocked", DW'({i_if.ready, d_if.ready}), DW'(2'b00));
    mem_spur = 1'b0; mem_stall = 1'b0;
    set_d(1'b0, '0);
    i_rst_n = 1'b1;
    tick();
    set_i(1'b1, 32'h0000_0400); set_d(1'b1, 32'h0000_0501);
    wait_done(who, a, ok);
    if (!ok) fail_now("post_rst_first");
    else chk("post_rst_first_d", DW'({who, a}), DW'({1'b1, 32'h0000_0501}));
    tick();
    set_d(1'b0, '0);
    wait_done(who, a, ok);
    if (!ok) fail_now("post_rst_second");
    else chk("post_rst_second_i", DW'({who, a}), DW'({1'b0, 32'h0000_0400}));
    tick();
    set_i(1'b0, '0);

    // fixed priority: 15 D grants, one I grant, D resumes
    losses = 0;
    for (int k = 0; k < 20; k++) begin
      if (losses == 15) begin fq.push_back(1'b0); losses = 0; end
      else begin fq.push_back(1'b1); losses++; end
    end
    fi_if.valid = 1'b1; fi_if.addr = 32'h0000_0010;
    fd_if.valid = 1'b1; fd_if.addr = 32'h0000_0021;
    ngr = 0;
    for (int g = 0; g < 400 && ngr < 20; g++) begin
      @(negedge i_clk);
      if (fm_if.valid && fm_if.ready) ngr++;
    end
    tick();
    fi_if.valid = 1'b0; fd_if.valid = 1'b0;
    chk("fix_grant_count", DW'(ngr), DW'(20));
    chk("fix_queue_drained", DW'(fq.size()), DW'(0));

    // randomized traffic, fresh reset so the model starts with last grant = I
    i_rst_n = 1'b0;
    tick(); tick();
    i_rst_n = 1'b1;
    mem_rand = 1'b1; mon_en = 1'b1;
    tick();
    fork
      begin : gen_i
        req_t r;
        int   w;
        for (int n = 0; n < NRAND; n++) begin
          repeat ($urandom_range(0, 3)) tick();
          r.addr = $urandom(); r.addr[0] = 1'b0;
          r.wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
          r.reqtyp = 1'($urandom_range(0, 1)); r.size = 3'($urandom_range(0, 7));
          r.cachable = 1'($urandom_range(0, 1));
          iq.push_back(r);
          i_if.addr = r.addr; i_if.wdata = r.wdata; i_if.reqtyp = r.reqtyp;
          i_if.size = r.size; i_if.cachable = r.cachable; i_if.valid = 1'b1;
          w = 0;
          do begin @(negedge i_clk); w++; end while (!i_if.ready && w < 100);
          if (!i_if.ready) fail_now("rand_i_timeout");
          tick();
          i_if.valid = 1'b0;
        end
      end
      begin : gen_d
        req_t r;
        int   w;
        for (int n = 0; n < NRAND; n++) begin
          repeat ($urandom_range(0, 3)) tick();
          r.addr = $urandom(); r.addr[0] = 1'b1;
          r.wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
          r.reqtyp = 1'($urandom_range(0, 1)); r.size = 3'($urandom_range(0, 7));
          r.cachable = 1'($urandom_range(0, 1));
          dq.push_back(r);
          d_if.addr = r.addr; d_if.wdata = r.wdata; d_if.reqtyp = r.reqtyp;
          d_if.size = r.size; d_if.cachable = r.cachable; d_if.valid = 1'b1;
          w = 0;
          do begin @(negedge i_clk); w++; end while (!d_if.ready && w < 100);
          if (!d_if.ready) fail_now("rand_d_timeout");
          tick();
          d_if.valid = 1'b0;
        end
      end
    join
    repeat (5) tick();
    mon_en = 1'b0;
    chk("rand_iq_drained", DW'(iq.size()), DW'(0));
    chk("rand_dq_drained", DW'(dq.size()), DW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the address width of all three ports (`ADR_WIDTH).
REQ-002 SHALL have parameter DATA_W, default 128, meaning the wdata/rdata width of all three ports.
REQ-003 SHALL have parameter FIX_PRIO, default 0, meaning 0 = round-robin, 1 = data port always wins a tie.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port iMemIf_S, uni_if.Slave, ADDR_W/DATA_W, the instruction-side requester (from iCache_wrapper iMemIf_M).
REQ-007 SHALL have port dMemIf_S, uni_if.Slave, ADDR_W/DATA_W, the data-side requester (from dCache wrapper).
REQ-008 SHALL have port memIf_M, uni_if.Master, ADDR_W/DATA_W, the single shared path to uni2axi.
REQ-009 Each uni_if SHALL carry valid, ready, reqtyp, addr, wdata, size, cachable (requester to memory) and rdata (memory to requester).

Function
REQ-010 Handshake rules:
- a requester holds valid and payload stable until it sees ready high for one cycle;
- ready is a single-cycle completion pulse, with rdata valid in that same cycle.
REQ-011 The FSM SHALL have states IDLE, GNT_I and GNT_D.
REQ-012 In IDLE, if exactly one requester has valid high, the next state SHALL be that requester's GNT state.
REQ-013 In IDLE, if both requesters have valid high, the winner SHALL be:
- FIX_PRIO=1: GNT_D;
- FIX_PRIO=0: the port not granted last, using last_gnt (reset value = I, so D wins the first tie).
REQ-014 In IDLE, if neither requester is valid, the FSM SHALL stay in IDLE.
REQ-015 In IDLE, memIf_M.valid SHALL be 0 and both slave ready outputs SHALL be 0; arbitration costs exactly one cycle.
REQ-016 In GNT_x, memIf_M valid, reqtyp, addr, wdata, size and cachable SHALL be driven combinationally from requester x.
REQ-017 In GNT_x, memIf_M.ready SHALL be routed only to requester x; the other requester's ready SHALL be 0.
REQ-018 rdata SHALL be broadcast to both requesters; consumers qualify it with their own ready.
REQ-019 In GNT_x, when memIf_M.ready is 1, the FSM SHALL return to IDLE next cycle and set last_gnt = x.
REQ-020 Back-to-back requests SHALL therefore be separated by one IDLE cycle; minimum occupancy per transaction is (memory latency + 1).
REQ-021 The grant SHALL never switch while in GNT_x, regardless of the other port's valid.
REQ-022 If requester x drops valid while in GNT_x (protocol violation), the arbiter SHALL stay in GNT_x, forwarding valid=0, until memIf_M.ready.
REQ-023 A memIf_M.ready pulse arriving in IDLE SHALL be ignored: no state change, and not routed to either requester.
REQ-024 The memIf_M.cachable value from the granted port SHALL be passed through unmodified (uni2axi size/len selection).
REQ-025 A starvation counter SHALL count consecutive losses of the same port in FIX_PRIO=1 mode, saturating at 15.
REQ-026 When the starvation counter is saturated at a tie, the losing port SHALL be granted once, then the counter SHALL clear.
REQ-027 The starvation counter SHALL be unused (held at 0) when FIX_PRIO=0.

Reset
REQ-028 On i_rst_n low, asynchronously: state=IDLE, last_gnt=I, starvation counter=0.
REQ-029 On i_rst_n low, asynchronously: memIf_M.valid=0, iMemIf_S.ready=0, dMemIf_S.ready=0, and all other memIf_M outputs 0.
REQ-030 Reset asserted mid-transaction SHALL abandon the grant immediately, with no ready delivered to either requester.
REQ-031 After reset release, arbitration SHALL restart from IDLE on the next rising edge.

Verification
REQ-032 Single I request, addr=0x8000_0000, memory ready 3 cycles after valid -> memIf_M.addr=0x8000_0000 from cycle 1; iMemIf_S.ready pulse exactly one cycle; dMemIf_S.ready stays 0.
REQ-033 FIX_PRIO=0, both valid continuously for 4 transactions -> grant order D,I,D,I with one IDLE cycle between each.
REQ-034 FIX_PRIO=1, both valid continuously -> 15 D grants, then 1 I grant, then D resumes.
REQ-035 During GNT_I, dMemIf_S.valid rises -> memIf_M payload stays I until ready; D is granted after the next IDLE cycle.
REQ-036 i_rst_n pulsed low during GNT_D with ready pending -> memIf_M.valid=0 in the same cycle; no dMemIf_S.ready; after release, a new request is served normally.
REQ-037 Spurious memIf_M.ready in IDLE -> no slave ready, state stays IDLE.
